// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO, runtime parity/stop config, frames sent back-to-back.
// Latency: word pushed into empty FIFO while idle is popped next edge; start bit on Sout one edge later.
// Backpressure: DinReady drops when FIFO holds FIFO_DEPTH words; rises again on the next pop.

module uart_tx_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          wr_vld,
  input  logic [W-1:0]  wr_dat,
  input  logic          rd_en,
  output logic [W-1:0]  rd_dat,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_go;
  logic          rd_go;

  // Guard both ports so the occupancy count can never over- or underflow.
  assign wr_go  = wr_vld && (count != CW'(DEPTH));
  assign rd_go  = rd_en && (count != '0);
  assign rd_dat = mem[rd_ptr];

  // Storage array: written on accepted pushes, no reset needed.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Pointers wrap naturally; count tracks occupancy and defines full/empty.
  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_go) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_go) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_go, rd_go})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                                 clk,
  input  logic                                 Reset,
  input  logic [DATA_BITS-1:0]                 Din,
  input  logic                                 DinValid,
  output logic                                 DinReady,
  input  logic [1:0]                           ParityMode,
  input  logic                                 TwoStop,
  output logic                                 Sout,
  output logic                                 Busy,
  output logic                                 TxDone,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      Count
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [TW-1:0]        timer;
  logic [IW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 par_en;
  logic                 two_stop;
  logic                 done_pend;

  logic                 bit_end;
  logic                 last_stop;
  logic                 pop;
  logic                 sout_nxt;
  logic                 done_evt;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dat;
  logic                 wr_vld;

  assign fifo_empty = (Count == '0);
  assign DinReady   = (Count != CW'(FIFO_DEPTH));
  assign wr_vld     = DinValid && DinReady;
  assign bit_end    = (timer == TW'(CLKS_PER_BIT - 1));
  assign last_stop  = (stop_idx == two_stop);
  assign Busy       = (state != S_IDLE);

  uart_tx_fifo_buf #(
    .W     (DATA_BITS),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_buf (
    .clk    (clk),
    .Reset  (Reset),
    .wr_vld (wr_vld),
    .wr_dat (Din),
    .rd_en  (pop),
    .rd_dat (fifo_dat),
    .count  (Count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, FIFO pop, next line level and end-of-frame event.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    sout_nxt  = 1'b1;
    done_evt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        sout_nxt = 1'b0;
        if (bit_end) begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        sout_nxt = shreg[0];
        if (bit_end && (bit_idx == IW'(DATA_BITS - 1))) begin
          state_nxt = par_en ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        sout_nxt = par_bit;
        if (bit_end) begin
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        sout_nxt = 1'b1;
        if (bit_end && last_stop) begin
          done_evt = 1'b1;
          // Chain straight into the next start bit when more words wait.
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Bit timer: runs only while framing, wraps at every bit boundary.
  always_ff @(posedge clk) begin
    if (Reset) begin
      timer <= '0;
    end else if ((state == S_IDLE) || bit_end) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  // Frame datapath: load word and frozen config on pop, shift data bits out LSB first.
  always_ff @(posedge clk) begin
    if (Reset) begin
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_bit  <= 1'b0;
      par_en   <= 1'b0;
      two_stop <= 1'b0;
    end else if (pop) begin
      shreg    <= fifo_dat;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      par_bit  <= (ParityMode == 2'b10) ? ~^fifo_dat : ^fifo_dat;
      par_en   <= (ParityMode == 2'b01) || (ParityMode == 2'b10);
      two_stop <= TwoStop;
    end else if (bit_end) begin
      if (state == S_DATA) begin
        shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + IW'(1);
      end
      if (state == S_STOP) begin
        stop_idx <= stop_idx + 1'b1;
      end
    end
  end

  // Registered line and done pulse; TxDone lags one extra edge so it lines up
  // with the cycle after the final stop bit has been on the line.
  always_ff @(posedge clk) begin
    if (Reset) begin
      Sout      <= 1'b1;
      done_pend <= 1'b0;
      TxDone    <= 1'b0;
    end else begin
      Sout      <= sout_nxt;
      done_pend <= done_evt;
      TxDone    <= done_pend;
    end
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised asynchronous serial transmitter with a built-in input FIFO. It replaces the fixed 8-bit, odd-parity, single-word Send/Sent transmitter with configurable bit period, data width, parity mode and stop-bit count. A valid/ready write port lets producers queue words, and frames go out back-to-back with no idle gap. It sits between the user-side datapath and the board TX pin.

## Interface

Parameters:
- CLKS_PER_BIT, 5208, clocks per serial bit (≥2); 5208 gives 19200 baud at 100 MHz
- DATA_BITS, 8, data bits per frame, 5..9
- FIFO_DEPTH, 4, word capacity, power of two, ≥2

Ports:
- clk  in  1  clock
- Reset  in  1  reset; reset Reset, synchronous, active-high; clock clk
- Din  in  DATA_BITS  word to queue
- DinValid  in  1  Din is valid this cycle
- DinReady  out  1  FIFO can accept a word (= not full)
- ParityMode  in  2  00 none, 01 even, 10 odd, 11 treated as none
- TwoStop  in  1  1 selects two stop bits, 0 selects one
- Sout  out  1  serial line, registered, idle high
- Busy  out  1  frame in progress
- TxDone  out  1  one-cycle pulse at end of each frame
- Count  out  $clog2(FIFO_DEPTH+1)  words in FIFO, excluding the frame in flight

## Operation

- Push happens on any edge with DinValid && DinReady. Pushes while full do not occur, because DinReady=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: Sout=1. If the FIFO is non-empty:
  - pop the word into the shift register
  - latch ParityMode and TwoStop
  - compute the parity bit
  - go to START
- START: Sout=0 for one bit period, then go to DATA with bit index 0.
- DATA: Sout = data[index], LSB first, each bit held one period. After bit DATA_BITS-1, go to PARITY if parity is enabled, else STOP.
- PARITY: Sout=even parity (^data) or odd parity (~^data), held one period.
- STOP: Sout=1 for 1 or 2 periods per the latched TwoStop. At the end of the last stop period:
  - TxDone pulses for one cycle.
  - If the FIFO is non-empty, pop on that same edge and enter START, so the start bit follows with zero idle cycles.
  - Otherwise go to IDLE.
- Config changes mid-frame do not affect the current frame.
- Bit timer counts 0..CLKS_PER_BIT-1. It clears on every state change and whenever the FSM is in IDLE.
- Busy=1 in every state except IDLE.
- Count increments on push and decrements on pop. A simultaneous push and pop leaves Count unchanged.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full and empty are derived from Count.

## Timing

- Reset values: Sout=1, DinReady=1, Busy=0, TxDone=0, Count=0.
- Reset has priority over all other activity. Reset mid-frame:
  - discards the in-flight word and the FIFO contents
  - Sout=1 on the next edge
  - no TxDone pulse
- Latency: a word pushed at edge N into an empty FIFO with the FSM idle:
  - Count=1 after N
  - pop at edge N+1 (Count=0, Busy=1)
  - Sout=0 visible after edge N+2
- Each bit is exactly CLKS_PER_BIT cycles on Sout.
- Frame length = CLKS_PER_BIT × (1 + DATA_BITS + P + S), where P ∈ {0,1} and S ∈ {1,2}.
- TxDone is asserted in the cycle after the last stop bit completes. It coincides with the next start bit when the FSM chains frames back-to-back.
- DinReady is combinational from Count and deasserts in the cycle after the push that fills the FIFO.

## Test plan

- Reset check: assert Reset for 3 cycles mid-stream -> Sout=1, DinReady=1, Busy=0, Count=0, TxDone=0.
- Single frame, odd parity, CLKS_PER_BIT=4, ParityMode=10, TwoStop=0, push 0xA5:
  - Sout = start 0, then 1,0,1,0,0,1,0,1, parity 1, stop 1, each bit 4 cycles
  - 44 cycles total
  - one TxDone pulse
- Even parity, two stops, push 0x07 with ParityMode=01, TwoStop=1 -> data 1,1,1,0,0,0,0,0, parity 1, then Sout high for 8 cycles before TxDone.
- Back-to-back, parity none: push 0x11, 0x22, 0x33 on consecutive cycles -> three contiguous 40-cycle frames with no idle gap, TxDone pulses 40 cycles apart, Count reaches 2 then drains.
- Full FIFO, FIFO_DEPTH=4: hold DinValid=1 continuously -> 5 words accepted (1 in flight plus 4 queued), DinReady=0 until the next pop, and Count never exceeds 4.
- Mid-frame reset and reconfig:
  - change ParityMode during the DATA bits -> the current frame keeps its latched mode
  - assert Reset during data bit 3 -> Sout=1 next cycle, Count=0, no TxDone
  - push after reset -> a normal frame follows
